fmc_slave_port: RTL and testbench
=================================

// Module: fmc_slave_port
// PURPOSE
// - Synchronous FMC (STM32 async SRAM-mode) responder on the FPGA side of the MCU bus; counterpart of the MCU-side initiator.
// - Samples the async strobes into clk; write cycles are pushed into a FIFO as (addr, data) words for the LCD/engine logic.
// - Read cycles are turned into a one-cycle request to internal logic; the returned word is driven back on the FMC data bus.
// PARAMETERS
// - NE_SEL      0   index of the fmc_ne[3:0] bank this port answers to
// - FIFO_DEPTH  16  write FIFO entries; power of two, 2..64
// - AW          24  address width carried into FIFO and read request
// PORTS
// - clk          in   1   core clock (PLL 168 MHz domain)
// - rst          in   1   synchronous reset, active low
// - fmc_ne       in   4   bank chip selects, active low, async
// - fmc_nwe      in   1   write strobe, active low, async
// - fmc_noe      in   1   read strobe, active low, async
// - fmc_addr     in   AW  address bus, async
// - fmc_data_i   in   16  data bus input, async
// - fmc_data_o   out  16  data bus output value
// - fmc_data_oe  out  1   data bus output enable (pad tristate control)
// - wr_valid     out  1   FIFO head valid
// - wr_ready     in   1   consumer accepts head when wr_valid & wr_ready
// - wr_addr      out  AW  FIFO head address
// - wr_data      out  16  FIFO head data
// - rd_req       out  1   one-cycle read request pulse
// - rd_addr      out  AW  read address, held from rd_req until next request
// - rd_valid     in   1   read data return strobe
// - rd_data      in   16  read data return value
// - clr_err      in   1   clears sticky flags
// - ovf          out  1   sticky: write dropped, FIFO full
// - rd_late      out  1   sticky: NOE released before rd_valid
// - proto_err    out  1   sticky: NWE and NOE both low
// - fifo_level   out  7   entries in FIFO (0..FIFO_DEPTH)
// BEHAVIOUR
// - Sync: ne/nwe/noe through 2 flops (synced = stage 2); fmc_addr/fmc_data_i registered 3 times, so stage 3 aligns with synced strobes.
// - cs = ~synced ne[NE_SEL]. Bus-timing contract: ADDSET >= 2 clk, DATAST >= 6 clk, so both strobes are stable >= 4 synced cycles.
// - FSM IDLE, WR_ACT, RD_WAIT, RD_DRIVE, ERR.
//   IDLE: cs & ~nwe & noe -> WR_ACT; cs & ~noe & nwe -> RD_WAIT (rd_req=1 this cycle, rd_addr <= aligned addr); cs & ~nwe & ~noe -> ERR.
//   WR_ACT: every cycle latch aligned addr/data into hold regs; on synced nwe rising (low->high): push hold regs into FIFO, -> IDLE.
//     NE rising together with or before NWE still commits (cs sampled at WR_ACT entry). noe low while in WR_ACT -> ERR, no push.
//   RD_WAIT: fmc_data_oe=1, fmc_data_o = previous value; rd_valid -> fmc_data_o <= rd_data, -> RD_DRIVE; noe high first -> rd_late=1, -> IDLE.
//   RD_DRIVE: hold fmc_data_o, oe=1; synced noe high or cs low -> IDLE (oe=0 same cycle as transition registers).
//   ERR: proto_err=1; oe=0; no push; -> IDLE once synced nwe & noe both high.
// - rd_valid outside RD_WAIT ignored. Read latency contract for internal logic: rd_valid within 3 clk of rd_req.
// - FIFO: push and pop in same cycle allowed; level unchanged. Full and push (no pop): write dropped, ovf=1. Empty: wr_valid=0, wr_addr/wr_data don't-care.
//   Full with simultaneous pop and push: both occur, no ovf. Pointers wrap mod FIFO_DEPTH.
// - Head regs are first-word-fall-through: wr_valid rises 1 clk after push into an empty FIFO.
// - clr_err clears all three stickies next cycle; a same-cycle new error event wins (flag stays 1).
// - Reset (rst=0 at clk edge): FSM IDLE, FIFO empty, fifo_level=0, wr_valid=0, rd_req=0, rd_addr=0,
//   fmc_data_o=0, fmc_data_oe=0, ovf/rd_late/proto_err=0, sync flops preset to inactive (1). Mid-cycle reset abandons the transfer; no push.
// - After reset, a bus cycle already in progress is ignored until both strobes are seen high (enter via IDLE only on a fresh falling edge).
// TESTING
// - Write: NE0 low, addr=0x000123, data=0xBEEF, NWE low 6 clk -> one FIFO entry 0x000123/0xBEEF, level 1, wr_valid 1 clk after NWE rise.
// - Read: NOE low 8 clk, addr=0x0000AA, rd_valid 2 clk after rd_req with 0x5A5A -> single rd_req, rd_addr=0xAA, fmc_data_o=0x5A5A, oe drops after NOE rise.
// - Overflow: wr_ready=0, FIFO_DEPTH+1 writes -> level=FIFO_DEPTH, ovf=1, head holds first word; clr_err -> ovf=0.
// - Simultaneous push/pop at full, wr_ready=1 -> level stays FIFO_DEPTH, ovf stays 0, order preserved over 40 writes.
// - NWE and NOE both low -> proto_err=1, no push, no rd_req, oe=0; late read (no rd_valid) -> rd_late=1.
// - rst=0 mid write (NWE low) -> FIFO empty; cycle with NE1 only (NE_SEL=0) -> no push, no rd_req.

Source files
------------

// File: rtl/fmc_slave_port.sv
// FPGA-side responder for the STM32 FMC bus in async-SRAM mode. Bus writes are
// queued into a first-word-fall-through FIFO; bus reads are forwarded to internal logic.
module fmc_slave_port #(
   parameter int NE_SEL     = 0,
   parameter int FIFO_DEPTH = 16,
   parameter int AW         = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    fmc_ne,
   input  logic          fmc_nwe,
   input  logic          fmc_noe,
   input  logic [AW-1:0] fmc_addr,
   input  logic [15:0]   fmc_data_i,
   output logic [15:0]   fmc_data_o,
   output logic          fmc_data_oe,
   output logic          wr_valid,
   input  logic          wr_ready,
   output logic [AW-1:0] wr_addr,
   output logic [15:0]   wr_data,
   output logic          rd_req,
   output logic [AW-1:0] rd_addr,
   input  logic          rd_valid,
   input  logic [15:0]   rd_data,
   input  logic          clr_err,
   output logic          ovf,
   output logic          rd_late,
   output logic          proto_err,
   output logic [6:0]    fifo_level
);

   localparam int         PW     = $clog2(FIFO_DEPTH);
   localparam logic [6:0] DEPTH7 = 7'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WR_ACT   = 3'd1,
      RD_WAIT  = 3'd2,
      RD_DRIVE = 3'd3,
      ERR      = 3'd4
   } state_t;

   logic          r_ne_p0, r_ne_p1;
   logic          r_nwe_p0, r_nwe_p1;
   logic          r_noe_p0, r_noe_p1;
   logic [AW-1:0] r_addr_p0, r_addr_p1, r_addr_p2;
   logic [15:0]   r_din_p0, r_din_p1, r_din_p2;
   logic [1:0]    r_warm;
   logic          r_armed;

   state_t        r_state, w_next;
   logic          w_cs, w_nwe, w_noe;
   logic          w_push, w_hold_en, w_rd_start, w_dout_ld;
   logic          w_err_evt, w_late_evt, w_oe_next;

   logic [AW-1:0] r_hold_addr;
   logic [15:0]   r_hold_data;
   logic [15:0]   r_dout;
   logic          r_oe;
   logic          r_rd_req;
   logic [AW-1:0] r_rd_addr;
   logic          r_ovf, r_rd_late, r_proto_err;

   logic [AW+15:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]  r_wptr, r_rptr;
   logic [6:0]     r_count;
   logic           w_full, w_pop, w_wr_ok, w_ovf_evt;
   logic [AW+15:0] w_head;
   logic           w_unused_ne;

   // Stage p0/p1: two-flop synchronisers for the strobes, preset inactive.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_ne_p0  <= 1'b1;
         r_ne_p1  <= 1'b1;
         r_nwe_p0 <= 1'b1;
         r_nwe_p1 <= 1'b1;
         r_noe_p0 <= 1'b1;
         r_noe_p1 <= 1'b1;
      end else begin
         r_ne_p0  <= fmc_ne[NE_SEL];
         r_ne_p1  <= r_ne_p0;
         r_nwe_p0 <= fmc_nwe;
         r_nwe_p1 <= r_nwe_p0;
         r_noe_p0 <= fmc_noe;
         r_noe_p1 <= r_noe_p0;
      end
   end

   // Stage p0..p2: address/data capture, one stage deeper than the strobes.
   always_ff @(posedge clk) begin
      r_addr_p0 <= fmc_addr;
      r_addr_p1 <= r_addr_p0;
      r_addr_p2 <= r_addr_p1;
      r_din_p0  <= fmc_data_i;
      r_din_p1  <= r_din_p0;
      r_din_p2  <= r_din_p1;
   end

   assign w_unused_ne = ^fmc_ne;
   assign w_cs        = ~r_ne_p1;
   assign w_nwe       = r_nwe_p1;
   assign w_noe       = r_noe_p1;

   // The preset synchroniser outputs are meaningless for two cycles after reset;
   // only arm once real strobes have been seen idle, so a cycle already in flight is skipped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_warm  <= 2'b00;
         r_armed <= 1'b0;
      end else begin
         r_warm <= {r_warm[0], 1'b1};
         if (r_warm[1] && w_nwe && w_noe)
            r_armed <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_push     = 1'b0;
      w_hold_en  = 1'b0;
      w_rd_start = 1'b0;
      w_dout_ld  = 1'b0;
      w_err_evt  = 1'b0;
      w_late_evt = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_armed && w_cs) begin
               if (!w_nwe && !w_noe) begin
                  w_next    = ERR;
                  w_err_evt = 1'b1;
               end else if (!w_nwe) begin
                  w_next    = WR_ACT;
                  w_hold_en = 1'b1;
               end else if (!w_noe) begin
                  w_next     = RD_WAIT;
                  w_rd_start = 1'b1;
               end
            end
         end
         WR_ACT: begin
            if (!w_noe) begin
               w_next    = ERR;
               w_err_evt = 1'b1;
            end else if (w_nwe) begin
               w_next = IDLE;
               w_push = 1'b1;
            end else begin
               w_hold_en = 1'b1;
            end
         end
         RD_WAIT: begin
            if (rd_valid) begin
               w_next    = RD_DRIVE;
               w_dout_ld = 1'b1;
            end else if (w_noe) begin
               w_next     = IDLE;
               w_late_evt = 1'b1;
            end
         end
         RD_DRIVE: begin
            if (w_noe || !w_cs)
               w_next = IDLE;
         end
         ERR: begin
            if (w_nwe && w_noe)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign w_oe_next = (w_next == RD_WAIT) || (w_next == RD_DRIVE);

   // Hold registers track the bus while NWE is low so the commit uses the last stable word.
   always_ff @(posedge clk) begin
      if (w_hold_en) begin
         r_hold_addr <= r_addr_p2;
         r_hold_data <= r_din_p2;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_oe        <= 1'b0;
         r_dout      <= 16'd0;
         r_rd_req    <= 1'b0;
         r_rd_addr   <= '0;
         r_ovf       <= 1'b0;
         r_rd_late   <= 1'b0;
         r_proto_err <= 1'b0;
      end else begin
         r_oe     <= w_oe_next;
         r_rd_req <= w_rd_start;
         if (w_rd_start)
            r_rd_addr <= r_addr_p2;
         if (w_dout_ld)
            r_dout <= rd_data;
         r_ovf       <= w_ovf_evt  | (r_ovf       & ~clr_err);
         r_rd_late   <= w_late_evt | (r_rd_late   & ~clr_err);
         r_proto_err <= w_err_evt  | (r_proto_err & ~clr_err);
      end
   end

   // Write FIFO: a push into a full FIFO only succeeds if the head pops in the same cycle.
   assign w_full    = (r_count == DEPTH7);
   assign w_pop     = (r_count != 7'd0) && wr_ready;
   assign w_wr_ok   = w_push && (!w_full || w_pop);
   assign w_ovf_evt = w_push && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_wr_ok)
         r_mem[r_wptr] <= {r_hold_addr, r_hold_data};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= 7'd0;
      end else begin
         if (w_wr_ok)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         case ({w_wr_ok, w_pop})
            2'b10:   r_count <= r_count + 7'd1;
            2'b01:   r_count <= r_count - 7'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign w_head      = r_mem[r_rptr];
   assign wr_valid    = (r_count != 7'd0);
   assign wr_addr     = w_head[AW+15:16];
   assign wr_data     = w_head[15:0];
   assign fifo_level  = r_count;

   assign fmc_data_o  = r_dout;
   assign fmc_data_oe = r_oe;
   assign rd_req      = r_rd_req;
   assign rd_addr     = r_rd_addr;
   assign ovf         = r_ovf;
   assign rd_late     = r_rd_late;
   assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_fmc_slave_port.sv
// Directed bench for fmc_slave_port: bus writes, reads, FIFO overflow and
// full-rate push/pop, protocol errors, late reads, mid-cycle reset, foreign bank.
module tb_fmc_slave_port;

   logic        clk;
   logic        rst;
   logic [3:0]  fmc_ne;
   logic        fmc_nwe, fmc_noe;
   logic [23:0] fmc_addr;
   logic [15:0] fmc_data_i;
   logic [15:0] fmc_data_o;
   logic        fmc_data_oe;
   logic        wr_valid, wr_ready;
   logic [23:0] wr_addr;
   logic [15:0] wr_data;
   logic        rd_req;
   logic [23:0] rd_addr;
   logic        rd_valid;
   logic [15:0] rd_data;
   logic        clr_err;
   logic        ovf, rd_late, proto_err;
   logic [6:0]  fifo_level;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;
   int rd_req_cnt = 0;
   int req_base;
   logic [39:0] q[$];
   logic [39:0] exp_w;

   fmc_slave_port #(.NE_SEL(0), .FIFO_DEPTH(16), .AW(24)) dut (
      .clk(clk), .rst(rst),
      .fmc_ne(fmc_ne), .fmc_nwe(fmc_nwe), .fmc_noe(fmc_noe),
      .fmc_addr(fmc_addr), .fmc_data_i(fmc_data_i),
      .fmc_data_o(fmc_data_o), .fmc_data_oe(fmc_data_oe),
      .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_valid(rd_valid), .rd_data(rd_data),
      .clr_err(clr_err),
      .ovf(ovf), .rd_late(rd_late), .proto_err(proto_err),
      .fifo_level(fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (rd_req === 1'b1) rd_req_cnt <= rd_req_cnt + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Full bus write; with pop set, the consumer takes the head exactly in the push cycle.
   task automatic bus_write(input int idx, input logic [23:0] a, input logic [15:0] d,
                            input bit pop);
      fmc_ne      = 4'hF;
      fmc_ne[idx] = 1'b0;
      fmc_addr    = a;
      fmc_data_i  = d;
      step(2);
      fmc_nwe = 1'b0;
      step(6);
      fmc_nwe = 1'b1;
      step(2);
      if (pop) begin
         exp_w = q.pop_front();
         chk("order", {24'd0, wr_addr, wr_data}, {24'd0, exp_w});
         wr_ready = 1'b1;
         q.push_back({a, d});
      end
      step(1);
      wr_ready = 1'b0;
      if (pop) chk("level_full", fifo_level, 7'd16);
      fmc_ne = 4'hF;
      step(2);
   endtask

   initial begin
      rst = 1'b0; fmc_ne = 4'hF; fmc_nwe = 1'b1; fmc_noe = 1'b1;
      fmc_addr = '0; fmc_data_i = '0; wr_ready = 1'b0;
      rd_valid = 1'b0; rd_data = '0; clr_err = 1'b0;
      step(3);
      chk("rst_level", fifo_level, 7'd0);
      chk("rst_wr_valid", wr_valid, 1'b0);
      chk("rst_rd_req", rd_req, 1'b0);
      chk("rst_rd_addr", rd_addr, 24'd0);
      chk("rst_data_o", fmc_data_o, 16'd0);
      chk("rst_oe", fmc_data_oe, 1'b0);
      chk("rst_flags", {ovf, rd_late, proto_err}, 3'b000);
      rst = 1'b1;
      step(5);

      // Basic write
      fmc_ne = 4'b1110; fmc_addr = 24'h000123; fmc_data_i = 16'hBEEF;
      step(2);
      fmc_nwe = 1'b0;
      step(6);
      fmc_nwe = 1'b1;
      step(2);
      chk("wr_valid_early", wr_valid, 1'b0);
      step(1);
      chk("wr_valid", wr_valid, 1'b1);
      chk("wr_level", fifo_level, 7'd1);
      chk("wr_addr", wr_addr, 24'h000123);
      chk("wr_data", wr_data, 16'hBEEF);
      fmc_ne = 4'hF;
      step(3);

      // Basic read
      req_base = rd_req_cnt;
      fmc_ne = 4'b1110; fmc_addr = 24'h0000AA;
      step(2);
      fmc_noe = 1'b0;
      step(3);
      chk("rd_req", rd_req, 1'b1);
      chk("rd_addr", rd_addr, 24'h0000AA);
      chk("rd_oe_wait", fmc_data_oe, 1'b1);
      step(2);
      rd_valid = 1'b1; rd_data = 16'h5A5A;
      step(1);
      rd_valid = 1'b0; rd_data = 16'h0000;
      chk("rd_data_o", fmc_data_o, 16'h5A5A);
      chk("rd_oe_drive", fmc_data_oe, 1'b1);
      step(2);
      fmc_noe = 1'b1;
      step(2);
      chk("rd_oe_hold", fmc_data_oe, 1'b1);
      step(1);
      chk("rd_oe_drop", fmc_data_oe, 1'b0);
      chk("rd_req_once", rd_req_cnt - req_base, 1);
      chk("rd_no_late", rd_late, 1'b0);
      chk("rd_addr_held", rd_addr, 24'h0000AA);
      fmc_ne = 4'hF;
      step(3);
      rd_valid = 1'b1; rd_data = 16'h1234;
      step(1);
      rd_valid = 1'b0;
      step(1);
      chk("rd_valid_ignored", fmc_data_o, 16'h5A5A);

      // Drain, then overflow
      wr_ready = 1'b1;
      step(1);
      wr_ready = 1'b0;
      chk("drain_one", fifo_level, 7'd0);
      for (int i = 0; i < 17; i++) begin
         if (i < 16) q.push_back({24'h000100 + 24'(i), 16'hA000 + 16'(i)});
         bus_write(0, 24'h000100 + 24'(i), 16'hA000 + 16'(i), 1'b0);
      end
      chk("ovf_level", fifo_level, 7'd16);
      chk("ovf_flag", ovf, 1'b1);
      chk("ovf_head", {wr_addr, wr_data}, {24'h000100, 16'hA000});
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;
      chk("ovf_clear", ovf, 1'b0);

      // Push and pop together while full
      for (int i = 0; i < 40; i++)
         bus_write(0, 24'h000200 + 24'(i), 16'hC000 + 16'(i), 1'b1);
      chk("full_no_ovf", ovf, 1'b0);
      wr_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         exp_w = q.pop_front();
         chk("drain_order", {24'd0, wr_addr, wr_data}, {24'd0, exp_w});
         step(1);
      end
      wr_ready = 1'b0;
      chk("drained_level", fifo_level, 7'd0);
      chk("drained_valid", wr_valid, 1'b0);

      // Protocol error
      req_base = rd_req_cnt;
      fmc_ne = 4'b1110; fmc_addr = 24'h000077; fmc_data_i = 16'h7777;
      step(2);
      fmc_nwe = 1'b0; fmc_noe = 1'b0;
      step(4);
      chk("perr_flag", proto_err, 1'b1);
      chk("perr_oe", fmc_data_oe, 1'b0);
      step(2);
      fmc_nwe = 1'b1; fmc_noe = 1'b1;
      step(4);
      fmc_ne = 4'hF;
      chk("perr_no_push", fifo_level, 7'd0);
      chk("perr_no_req", rd_req_cnt - req_base, 0);
      chk("perr_sticky", proto_err, 1'b1);
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;
      chk("perr_clear", proto_err, 1'b0);

      // Late read
      req_base = rd_req_cnt;
      fmc_ne = 4'b1110; fmc_addr = 24'h000055;
      step(2);
      fmc_noe = 1'b0;
      step(8);
      fmc_noe = 1'b1;
      step(4);
      fmc_ne = 4'hF;
      chk("late_flag", rd_late, 1'b1);
      chk("late_req", rd_req_cnt - req_base, 1);
      chk("late_oe", fmc_data_oe, 1'b0);
      clr_err = 1'b1;
      step(1);
      clr_err = 1'b0;
      chk("late_clear", rd_late, 1'b0);

      // Reset in the middle of a write
      fmc_ne = 4'b1110; fmc_addr = 24'h000999; fmc_data_i = 16'h9999;
      step(2);
      fmc_nwe = 1'b0;
      step(4);
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      step(3);
      fmc_nwe = 1'b1;
      step(4);
      fmc_ne = 4'hF;
      step(2);
      chk("mid_rst_level", fifo_level, 7'd0);
      chk("mid_rst_valid", wr_valid, 1'b0);

      // Foreign bank
      req_base = rd_req_cnt;
      bus_write(1, 24'h000321, 16'h4321, 1'b0);
      chk("ne1_no_push", fifo_level, 7'd0);
      fmc_ne = 4'b1101; fmc_addr = 24'h000321;
      step(2);
      fmc_noe = 1'b0;
      step(8);
      chk("ne1_oe", fmc_data_oe, 1'b0);
      fmc_noe = 1'b1;
      step(4);
      fmc_ne = 4'hF;
      chk("ne1_no_req", rd_req_cnt - req_base, 0);

      // Normal write still accepted after the mid-cycle reset
      bus_write(0, 24'h000ABC, 16'h0ABC, 1'b0);
      chk("post_rst_level", fifo_level, 7'd1);
      chk("post_rst_head", {wr_addr, wr_data}, {24'h000ABC, 16'h0ABC});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
